// File: rtl/difftest_pkg.sv
// Shared record layout for the difftest commit queue.
// One record holds the WB-side state of a single retired lane.
package difftest_pkg;

  localparam int REC_W     = 114;
  localparam int PC_OFF    = 0;
  localparam int INST_OFF  = 32;
  localparam int WEN_OFF   = 64;
  localparam int WDEST_OFF = 65;
  localparam int WDATA_OFF = 73;
  localparam int EXCP_OFF  = 105;
  localparam int ERTN_OFF  = 106;
  localparam int ECODE_OFF = 107;
  localparam int PAD_OFF   = 113;

  localparam logic [31:0] TRAP_INST_DEF = 32'h8000_0000;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic        wen,
    input logic [7:0]  wdest,
    input logic [31:0] wdata,
    input logic        excp,
    input logic        ertn,
    input logic [5:0]  ecode
  );
    logic [REC_W-1:0] r;
    r                     = '0;
    r[PC_OFF+:32]         = pc;
    r[INST_OFF+:32]       = inst;
    r[WEN_OFF]            = wen;
    r[WDEST_OFF+:8]       = wdest;
    r[WDATA_OFF+:32]      = wdata;
    r[EXCP_OFF]           = excp;
    r[ERTN_OFF]           = ertn;
    r[ECODE_OFF+:6]       = ecode;
    return r;
  endfunction

endpackage

// File: rtl/dt_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Registered storage, combinational head read.
module dt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/difftest_commit_queue.sv
// Multi-lane difftest commit queue: trap masking, lane packing,
// cycle/instr counters and trap/overflow flags around a bundle FIFO.
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int          NUM_LANES = 2,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] TRAP_INST = TRAP_INST_DEF
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   in_valid,
  input  logic [32*NUM_LANES-1:0] in_pc,
  input  logic [32*NUM_LANES-1:0] in_inst,
  input  logic [NUM_LANES-1:0]   in_wen,
  input  logic [8*NUM_LANES-1:0] in_wdest,
  input  logic [32*NUM_LANES-1:0] in_wdata,
  input  logic [NUM_LANES-1:0]   in_excp,
  input  logic [NUM_LANES-1:0]   in_ertn,
  input  logic [6*NUM_LANES-1:0] in_ecode,
  input  logic [31:0]            in_a0,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_LANES-1:0]   out_lane_valid,
  output logic [32*NUM_LANES-1:0] out_pc,
  output logic [32*NUM_LANES-1:0] out_inst,
  output logic [NUM_LANES-1:0]   out_wen,
  output logic [8*NUM_LANES-1:0] out_wdest,
  output logic [32*NUM_LANES-1:0] out_wdata,
  output logic [NUM_LANES-1:0]   out_excp,
  output logic [NUM_LANES-1:0]   out_ertn,
  output logic [6*NUM_LANES-1:0] out_ecode,
  output logic                   trap_valid,
  output logic [7:0]             trap_code,
  output logic [63:0]            cycle_cnt,
  output logic [63:0]            instr_cnt,
  output logic                   overflow_err
);

  localparam int NL  = NUM_LANES;
  localparam int RW  = NL * REC_W;
  localparam int FW  = RW + NL + 1;

  logic          trap_seen;
  logic          trap_done;
  logic [NL-1:0] lane_mask;
  logic          trap_hit;
  logic [RW-1:0] recs;
  logic [FW-1:0] head;
  logic [NL-1:0] pad_bits;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          unused_bits;

  // Lanes younger than the first trap lane never retire.
  always_comb begin
    lane_mask = in_valid;
    trap_hit  = 1'b0;
    recs      = '0;
    for (int i = 0; i < NL; i++) begin
      if (trap_hit) begin
        lane_mask[i] = 1'b0;
      end else if (in_valid[i] &&
                   in_inst[32*i+:32] == TRAP_INST) begin
        trap_hit = 1'b1;
      end
      recs[REC_W*i+:REC_W] = pack_rec(
        in_pc[32*i+:32], in_inst[32*i+:32],
        in_wen[i], in_wdest[8*i+:8],
        in_wdata[32*i+:32], in_excp[i],
        in_ertn[i], in_ecode[6*i+:6]);
    end
  end

  assign in_ready  = ~full & ~trap_seen;
  assign push      = (|in_valid) & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & ~trap_done;
  assign trap_valid = pop & head[FW-1];

  dt_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk  (aclk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({trap_hit, lane_mask, recs}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    logic [REC_W-1:0] r;
    out_lane_valid = head[RW+:NL] & {NL{out_valid}};
    out_pc    = '0;
    out_inst  = '0;
    out_wen   = '0;
    out_wdest = '0;
    out_wdata = '0;
    out_excp  = '0;
    out_ertn  = '0;
    out_ecode = '0;
    pad_bits  = '0;
    for (int i = 0; i < NL; i++) begin
      r = head[REC_W*i+:REC_W] & {REC_W{out_valid}};
      out_pc[32*i+:32]    = r[PC_OFF+:32];
      out_inst[32*i+:32]  = r[INST_OFF+:32];
      out_wen[i]          = r[WEN_OFF];
      out_wdest[8*i+:8]   = r[WDEST_OFF+:8];
      out_wdata[32*i+:32] = r[WDATA_OFF+:32];
      out_excp[i]         = r[EXCP_OFF];
      out_ertn[i]         = r[ERTN_OFF];
      out_ecode[6*i+:6]   = r[ECODE_OFF+:6];
      pad_bits[i]         = r[PAD_OFF];
    end
  end

  assign unused_bits = ^{pad_bits, in_a0[31:8]};

  always_ff @(posedge aclk) begin
    if (reset) begin
      cycle_cnt    <= '0;
      instr_cnt    <= '0;
      trap_seen    <= 1'b0;
      trap_done    <= 1'b0;
      trap_code    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (!trap_done) cycle_cnt <= cycle_cnt + 64'd1;
      if (pop)
        instr_cnt <= instr_cnt + 64'($countones(out_lane_valid));
      if (trap_valid) trap_done <= 1'b1;
      if (push && trap_hit) begin
        trap_seen <= 1'b1;
        trap_code <= in_a0[7:0];
      end
      if ((|in_valid) && full && !trap_seen) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed self-checking bench for difftest_commit_queue.
// Inputs driven and outputs sampled on the falling edge.
module tb_difftest_commit_queue;

  localparam int NL = 2;
  localparam logic [31:0] TRAP = 32'h8000_0000;

  logic          aclk;
  logic          reset;
  logic [NL-1:0] in_valid;
  logic [63:0]   in_pc;
  logic [63:0]   in_inst;
  logic [NL-1:0] in_wen;
  logic [15:0]   in_wdest;
  logic [63:0]   in_wdata;
  logic [NL-1:0] in_excp;
  logic [NL-1:0] in_ertn;
  logic [11:0]   in_ecode;
  logic [31:0]   in_a0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [NL-1:0] out_lane_valid;
  logic [63:0]   out_pc;
  logic [63:0]   out_inst;
  logic [NL-1:0] out_wen;
  logic [15:0]   out_wdest;
  logic [63:0]   out_wdata;
  logic [NL-1:0] out_excp;
  logic [NL-1:0] out_ertn;
  logic [11:0]   out_ecode;
  logic          trap_valid;
  logic [7:0]    trap_code;
  logic [63:0]   cycle_cnt;
  logic [63:0]   instr_cnt;
  logic          overflow_err;

  int passed = 0;
  int total  = 0;

  difftest_commit_queue #(
    .NUM_LANES (NL),
    .DEPTH     (8),
    .TRAP_INST (TRAP)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_wen         (in_wen),
    .in_wdest       (in_wdest),
    .in_wdata       (in_wdata),
    .in_excp        (in_excp),
    .in_ertn        (in_ertn),
    .in_ecode       (in_ecode),
    .in_a0          (in_a0),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_wen        (out_wen),
    .out_wdest      (out_wdest),
    .out_wdata      (out_wdata),
    .out_excp       (out_excp),
    .out_ertn       (out_ertn),
    .out_ecode      (out_ecode),
    .trap_valid     (trap_valid),
    .trap_code      (trap_code),
    .cycle_cnt      (cycle_cnt),
    .instr_cnt      (instr_cnt),
    .overflow_err   (overflow_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_pc    = '0;
    in_inst  = '0;
    in_wen   = '0;
    in_wdest = '0;
    in_wdata = '0;
    in_excp  = '0;
    in_ertn  = '0;
    in_ecode = '0;
    in_a0    = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc,
                          input logic [31:0] inst,
                          input logic [7:0] wdest,
                          input logic [31:0] wdata);
    in_pc[32*l+:32]    = pc;
    in_inst[32*l+:32]  = inst;
    in_wen[l]          = 1'b1;
    in_wdest[8*l+:8]   = wdest;
    in_wdata[32*l+:32] = wdata;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    repeat (3) @(negedge aclk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_instr_cnt", instr_cnt, 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_trap_valid", 64'(trap_valid), 64'd0);
    chk("rst_trap_code", 64'(trap_code), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] p0, p1, d0, d1;
    out_ready = 1'b1;
    chk("basic_empty", 64'(out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      p0 = 32'h1000 + 32'(8 * k);
      p1 = p0 + 32'd4;
      d0 = 32'hA000_0000 + 32'(16 * k);
      d1 = d0 + 32'd1;
      in_valid = 2'b11;
      set_lane(0, p0, 32'h0010_0093, 8'(4 + 2 * k), d0);
      set_lane(1, p1, 32'h0020_0113, 8'(5 + 2 * k), d1);
      @(negedge aclk);
      chk("basic_valid", 64'(out_valid), 64'd1);
      chk("basic_pc", out_pc, {p1, p0});
      chk("basic_wdata", out_wdata, {d1, d0});
      chk("basic_wdest", 64'(out_wdest),
          64'({8'(5 + 2 * k), 8'(4 + 2 * k)}));
      chk("basic_lanes", 64'(out_lane_valid), 64'd3);
    end
    clear_inputs();
    @(negedge aclk);
    chk("basic_drained", 64'(out_valid), 64'd0);
    chk("basic_instr_cnt", instr_cnt, 64'd6);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("ovf_in_ready", 64'(in_ready), (i < 8) ? 64'd1 : 64'd0);
      clear_inputs();
      in_valid = 2'b01;
      set_lane(0, 32'h2000 + 32'(4 * i), 32'h13, 8'd1, 32'(i));
      @(negedge aclk);
    end
    clear_inputs();
    chk("ovf_err", 64'(overflow_err), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_pop_valid", 64'(out_valid), 64'd1);
      chk("ovf_pop_pc", 64'(out_pc[31:0]), 64'(32'h2000 + 4 * i));
      chk("ovf_pop_lanes", 64'(out_lane_valid), 64'd1);
      @(negedge aclk);
    end
    chk("ovf_drained", 64'(out_valid), 64'd0);
    chk("ovf_instr_cnt", instr_cnt, 64'd14);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clear_inputs();
      in_valid = 2'b10;
      set_lane(1, 32'h3000 + 32'(4 * i), 32'h13, 8'd2, 32'(i));
      @(negedge aclk);
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      chk("b2b_pc", 64'(out_pc[63:32]), 64'(32'h3000 + 4 * i));
      chk("b2b_wdata", 64'(out_wdata[63:32]), 64'(i));
      chk("b2b_lanes", 64'(out_lane_valid), 64'd2);
    end
    clear_inputs();
    @(negedge aclk);
    chk("b2b_drained", 64'(out_valid), 64'd0);
    chk("b2b_instr_cnt", instr_cnt, 64'd34);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      in_valid = 2'b11;
      set_lane(0, 32'h4000 + 32'(8 * i), 32'h13, 8'd3, 32'd0);
      set_lane(1, 32'h4004 + 32'(8 * i), 32'h13, 8'd4, 32'd0);
      @(negedge aclk);
    end
    clear_inputs();
    chk("mid_queued", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge aclk);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_instr_cnt", instr_cnt, 64'd0);
    chk("mid_cycle_cnt", cycle_cnt, 64'd0);
    chk("mid_overflow", 64'(overflow_err), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(negedge aclk);
    chk("mid_still_empty", 64'(out_valid), 64'd0);
    chk("mid_cycle_one", cycle_cnt, 64'd1);
  endtask

  task automatic test_trap();
    out_ready = 1'b0;
    clear_inputs();
    in_valid = 2'b11;
    in_a0    = 32'h0000_0155;
    set_lane(0, 32'h5000, TRAP, 8'd0, 32'd0);
    set_lane(1, 32'h5004, 32'h13, 8'd5, 32'd7);
    @(negedge aclk);
    chk("trap_head_valid", 64'(out_valid), 64'd1);
    chk("trap_masked", 64'(out_lane_valid), 64'd1);
    chk("trap_inst", 64'(out_inst[31:0]), 64'(TRAP));
    chk("trap_in_ready", 64'(in_ready), 64'd0);
    chk("trap_no_pulse", 64'(trap_valid), 64'd0);
    clear_inputs();
    in_valid = 2'b11;
    set_lane(0, 32'h6000, 32'h13, 8'd1, 32'd1);
    set_lane(1, 32'h6004, 32'h13, 8'd2, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("trap_pulse", 64'(trap_valid), 64'd1);
    @(negedge aclk);
    chk("trap_pulse_end", 64'(trap_valid), 64'd0);
    chk("trap_code", 64'(trap_code), 64'h55);
    chk("trap_cycle_cnt", cycle_cnt, 64'd2);
    chk("trap_instr_cnt", instr_cnt, 64'd1);
    chk("trap_empty", 64'(out_valid), 64'd0);
    chk("trap_no_ovf", 64'(overflow_err), 64'd0);
    repeat (5) @(negedge aclk);
    chk("trap_cycle_frozen", cycle_cnt, 64'd2);
    chk("trap_instr_frozen", instr_cnt, 64'd1);
    chk("trap_ignored", 64'(out_valid), 64'd0);
    chk("trap_ready_low", 64'(in_ready), 64'd0);
    chk("trap_no_ovf_end", 64'(overflow_err), 64'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_reset();
    test_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
